bitstream_reader: RTL and testbench

BITSTREAM_READER -- requirements
Module: bitstream_reader

---
 rtl/bitstream_reader.sv | 96 +++++++++
 tb/tb_bitstream_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bitstream_reader.sv
// bitstream_reader
//   Splits a stream of MSB-first DATA_W-bit words into variable-length fields
//   of 0..MAX_LEN bits. Bits are held in a 2*DATA_W-bit left-aligned buffer,
//   with the oldest bit in the top position.
//
//   Ports
//     clk_i   : clock; all state updates on the rising edge
//     rst_ni  : asynchronous active-low reset
//     clr_i   : synchronous clear; discards buffered bits and blocks handshakes
//     data_i  : incoming word; bit DATA_W-1 is the oldest bit
//     vld_i   : data_i valid
//     rdy_o   : a word can be accepted this cycle
//     len_i   : number of bits requested by the consumer (0..MAX_LEN)
//     dout_o  : requested field, right-aligned, upper bits zero
//     vld_o   : dout_o holds len_i valid bits
//     rdy_i   : consumer takes the field this cycle
`timescale 1ns/1ps
module bitstream_reader #(
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               vld_i,
  output logic               rdy_o,
  input  logic [LEN_W-1:0]   len_i,
  output logic [MAX_LEN-1:0] dout_o,
  output logic               vld_o,
  input  logic               rdy_i
);

  localparam int BUF_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0]   r_buf;
  logic [FILL_W-1:0]  r_fill;

  logic [FILL_W-1:0]  w_len;
  logic [MAX_LEN-1:0] w_top;
  logic [LEN_W:0]     w_rsh;
  logic               w_pop;
  logic               w_push;
  logic [BUF_W-1:0]   w_buf_kept;
  logic [FILL_W-1:0]  w_fill_kept;
  logic [BUF_W-1:0]   w_buf_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;

  assign w_len = FILL_W'(len_i);

  // A word is only accepted when it is guaranteed to fit, even with no pop.
  assign rdy_o = (r_fill <= FILL_W'(DATA_W)) && !clr_i;
  assign vld_o = (r_fill >= w_len) && !clr_i;

  // Oldest MAX_LEN bits, then right-align the requested len_i of them.
  // len_i = 0 shifts by the full width, which yields zero.
  assign w_top  = r_buf[BUF_W-1 -: MAX_LEN];
  assign w_rsh  = (LEN_W + 1)'(MAX_LEN) - (LEN_W + 1)'(len_i);
  assign dout_o = w_top >> w_rsh;

  assign w_pop  = vld_o && rdy_i;
  assign w_push = vld_i && rdy_o;

  always_comb begin
    w_buf_kept  = r_buf;
    w_fill_kept = r_fill;
    if (w_pop) begin
      w_buf_kept  = r_buf << w_len;
      w_fill_kept = r_fill - w_len;
    end
    w_buf_nxt  = w_buf_kept;
    w_fill_nxt = w_fill_kept;
    // Bits below the fill level are always zero, so the new word can be
    // OR-ed in directly beneath whatever survives a same-cycle pop.
    if (w_push) begin
      w_buf_nxt  = w_buf_kept | ({data_i, {DATA_W{1'b0}}} >> w_fill_kept);
      w_fill_nxt = w_fill_kept + FILL_W'(DATA_W);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (clr_i) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else begin
      r_buf  <= w_buf_nxt;
      r_fill <= w_fill_nxt;
    end
  end

endmodule

// File: tb/tb_bitstream_reader.sv
`timescale 1ns/1ps
module tb_bitstream_reader;

  localparam int DW = 32;
  localparam int ML = 32;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] data = '0;
  logic          vld_i = 1'b0;
  logic          rdy_o;
  logic [LW-1:0] len = '0;
  logic [ML-1:0] dout;
  logic          vld_o;
  logic          rdy_i = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of buffered bits, oldest first.
  logic          mq[$];
  // Scoreboard of expected fields awaiting the DUT.
  logic [ML-1:0] sbq[$];

  bitstream_reader #(.DATA_W(DW), .MAX_LEN(ML)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (clr),
    .data_i(data),
    .vld_i (vld_i),
    .rdy_o (rdy_o),
    .len_i (len),
    .dout_o(dout),
    .vld_o (vld_o),
    .rdy_i (rdy_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    int          l;
    logic        r;
    logic        c;
    logic        cd;
    logic [31:0] ed;
    int          ef;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; outputs sampled at the falling edge.
  task automatic cycle(input logic v, input logic [31:0] d, input int l,
                       input logic r, input logic c, output logic [31:0] got);
    logic          exp_rdy, exp_vld, popped, pushed;
    logic [ML-1:0] f, e;
    vld_i = v; data = d; len = LW'(l); rdy_i = r; clr = c;
    @(negedge clk);
    exp_rdy = (mq.size() <= DW) && !c;
    exp_vld = (mq.size() >= l) && !c;
    chk("rdy_o", 64'(rdy_o), 64'(exp_rdy));
    chk("vld_o", 64'(vld_o), 64'(exp_vld));
    popped = exp_vld && r;
    pushed = exp_rdy && v;
    got = dout;
    if (popped) begin
      f = '0;
      for (int i = 0; i < l; i++) f = {f[ML-2:0], mq[i]};
      sbq.push_back(f);
    end
    if (popped && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("dout_o", 64'(dout), 64'(e));
      for (int i = 0; i < l; i++) void'(mq.pop_front());
    end
    if (pushed) for (int i = DW - 1; i >= 0; i--) mq.push_back(d[i]);
    if (c) mq.delete();
    @(posedge clk);
    #1;
    chk("fill", 64'(dut.r_fill), 64'(mq.size()));
  endtask

  initial begin
    logic [31:0] got;

    // Reset state
    rst_n = 1'b0;
    len = LW'(5);
    #2;
    chk("rst_rdy", 64'(rdy_o), 64'd1);
    chk("rst_vld_len5", 64'(vld_o), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    len = '0;
    #1;
    chk("rst_vld_len0", 64'(vld_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // v, data, len, rdy_i, clr, check-dout, expected dout, expected fill
    tbl.push_back('{1'b1, 32'hA500_0000,  0, 1'b0, 1'b0, 1'b0, 32'h0,          32});
    tbl.push_back('{1'b0, 32'h0,          4, 1'b1, 1'b0, 1'b1, 32'h0000_000A,  28});
    tbl.push_back('{1'b0, 32'h0,          4, 1'b1, 1'b0, 1'b1, 32'h0000_0005,  24});
    tbl.push_back('{1'b0, 32'h0,          0, 1'b0, 1'b1, 1'b0, 32'h0,           0});
    tbl.push_back('{1'b1, 32'hFFFF_FFF0,  0, 1'b0, 1'b0, 1'b0, 32'h0,          32});
    tbl.push_back('{1'b0, 32'h0,         28, 1'b1, 1'b0, 1'b1, 32'h0FFF_FFFF,   4});
    tbl.push_back('{1'b1, 32'h8000_0000,  0, 1'b0, 1'b0, 1'b0, 32'h0,          36});
    tbl.push_back('{1'b0, 32'h0,          8, 1'b1, 1'b0, 1'b1, 32'h0000_0008,  28});
    tbl.push_back('{1'b0, 32'h0,          0, 1'b0, 1'b1, 1'b0, 32'h0,           0});
    tbl.push_back('{1'b1, 32'hDEAD_BEEF,  0, 1'b0, 1'b0, 1'b0, 32'h0,          32});
    tbl.push_back('{1'b1, 32'h1234_5678, 32, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF,  32});
    tbl.push_back('{1'b0, 32'h0,         32, 1'b1, 1'b0, 1'b1, 32'h1234_5678,   0});
    tbl.push_back('{1'b0, 32'h0,          0, 1'b1, 1'b0, 1'b1, 32'h0,           0});

    foreach (tbl[k]) begin
      cycle(tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].r, tbl[k].c, got);
      if (tbl[k].cd) chk($sformatf("tbl%0d_dout", k), 64'(got), 64'(tbl[k].ed));
      chk($sformatf("tbl%0d_fill", k), 64'(dut.r_fill), 64'(tbl[k].ef));
    end

    // Backpressure: reach fill 40, hold vld_i with a pending word
    cycle(1'b1, 32'hAAAA_AAAA,  0, 1'b0, 1'b0, got);
    cycle(1'b1, 32'h5555_5555, 24, 1'b1, 1'b0, got);
    chk("bp_fill40", 64'(dut.r_fill), 64'd40);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hC3C3_1234, 0, 1'b0, 1'b0, got);
      chk("bp_blocked", 64'(rdy_o), 64'd0);
    end
    cycle(1'b1, 32'hC3C3_1234, 10, 1'b1, 1'b0, got);
    chk("bp_fill30", 64'(dut.r_fill), 64'd30);
    chk("bp_rdy_after_pop", 64'(rdy_o), 64'd1);
    cycle(1'b1, 32'hC3C3_1234, 0, 1'b0, 1'b0, got);
    chk("bp_accept_once", 64'(dut.r_fill), 64'd62);
    cycle(1'b0, 32'h0, 31, 1'b1, 1'b0, got);
    cycle(1'b0, 32'h0, 31, 1'b1, 1'b0, got);
    chk("bp_drained", 64'(dut.r_fill), 64'd0);

    // Clear with fill 45 and both handshakes requested
    cycle(1'b1, 32'h0F0F_0F0F,  0, 1'b0, 1'b0, got);
    cycle(1'b1, 32'hF00D_CAFE, 19, 1'b1, 1'b0, got);
    chk("clr_fill45", 64'(dut.r_fill), 64'd45);
    cycle(1'b1, 32'h1111_1111, 5, 1'b1, 1'b1, got);
    chk("clr_fill0", 64'(dut.r_fill), 64'd0);
    cycle(1'b0, 32'h0, 1, 1'b1, 1'b0, got);
    chk("clr_vld_len1", 64'(vld_o), 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, ML)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), got);
    end

    // Reset asserted mid-stream discards everything
    cycle(1'b1, 32'hBEEF_0001, 0, 1'b0, 1'b0, got);
    vld_i = 1'b0; rdy_i = 1'b0; len = LW'(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fill", 64'(dut.r_fill), 64'd0);
    chk("mid_rst_vld", 64'(vld_o), 64'd0);
    chk("mid_rst_rdy", 64'(rdy_o), 64'd1);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 32'h0, 1, 1'b1, 1'b0, got);
    chk("post_rst_no_field", 64'(vld_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
